// File: rtl/rev_pipe_pkg.sv
// rev_pipe_pkg: shared types, constants and the permutation helper used by
// rev_capture_pipe and its pipeline slices.
package rev_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_PASS       = 2'b00,
      MODE_BITREV     = 2'b01,
      MODE_LANEREV    = 2'b10,
      MODE_LANEBITREV = 2'b11
   } mode_e;

   localparam int unsigned COUNT_W    = 16;
   // Widest vector the permutation helper handles (WIDTH*LANES must not exceed it).
   localparam int unsigned PERM_MAX_N = 256;
   localparam int unsigned PERM_IDX_W = $clog2(PERM_MAX_N);

   // Bit j of the result is taken from a[src(j)]; bits at or above width*lanes are 0.
   function automatic logic [PERM_MAX_N-1:0] rev_permute(
      input logic [PERM_MAX_N-1:0] a,
      input mode_e                 mode,
      input int unsigned           width,
      input int unsigned           lanes
   );
      logic [PERM_MAX_N-1:0] r;
      logic [PERM_IDX_W-1:0] jdx;
      logic [PERM_IDX_W-1:0] src;
      int unsigned           n;
      int unsigned           lane;
      int unsigned           bitpos;
      r = '0;
      n = width * lanes;
      for (int unsigned j = 0; j < PERM_MAX_N; j++) begin
         jdx    = PERM_IDX_W'(j);
         lane   = j / width;
         bitpos = j % width;
         case (mode)
            MODE_PASS:    src = jdx;
            MODE_BITREV:  src = PERM_IDX_W'(n - 1 - j);
            MODE_LANEREV: src = PERM_IDX_W'((lanes - 1 - lane) * width + bitpos);
            default:      src = PERM_IDX_W'(lane * width + (width - 1 - bitpos));
         endcase
         if (j < n) r[jdx] = a[src];
      end
      return r;
   endfunction

endpackage

// File: rtl/rev_pipe_slice.sv
// rev_pipe_slice: one valid/data register slice with valid/ready handshake.
// Accepts whenever enabled and either empty or draining downstream this cycle.
module rev_pipe_slice #(
   parameter int unsigned N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_data
);

   logic         valid_q;
   logic [N-1:0] data_q;

   // Upstream ready: forced low in reset and while the pipeline is frozen.
   always_comb o_ready = i_rst_n & i_en & (~valid_q | i_ready);

   // Capture a new beat (or a bubble) whenever this slice accepts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (o_ready) begin
         valid_q <= i_valid;
         if (i_valid) data_q <= i_data;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: rtl/rev_capture_pipe.sv
// rev_capture_pipe: multi-lane capture, selectable bit/lane permutation and a
// STAGES-deep valid/ready register pipeline with global enable.
// Optional feature macro: REV_PIPE_COUNT_EN adds i_count_clr / o_count, a
// saturating count of output transfers.
module rev_capture_pipe
   import rev_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned LANES  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [WIDTH*LANES-1:0] i_a,
   input  logic [1:0]             i_mode,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH*LANES-1:0] o_a
`ifdef REV_PIPE_COUNT_EN
   ,
   input  logic                   i_count_clr,
   output logic [COUNT_W-1:0]     o_count
`endif
);

   localparam int unsigned N = WIDTH * LANES;

   logic [N-1:0] perm;

   // Permutation front end; stages behind it only move data.
   always_comb perm = N'(rev_permute(PERM_MAX_N'(i_a), mode_e'(i_mode), WIDTH, LANES));

   // Each stage keeps its own link nets so the ready chain is not a
   // self-dependent vector.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic         up_valid;
      logic         up_ready;
      logic [N-1:0] up_data;
      logic         dn_valid;
      logic         dn_ready;
      logic [N-1:0] dn_data;

      if (s == 0) begin : g_head
         assign up_valid = i_valid;
         assign up_data  = perm;
      end else begin : g_link
         assign up_valid = g_stage[s-1].dn_valid;
         assign up_data  = g_stage[s-1].dn_data;
      end

      if (s == STAGES - 1) begin : g_tail
         assign dn_ready = i_ready;
      end else begin : g_fwd
         assign dn_ready = g_stage[s+1].up_ready;
      end

      rev_pipe_slice #(.N(N)) u_slice (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_en    (i_en),
         .i_valid (up_valid),
         .o_ready (up_ready),
         .i_data  (up_data),
         .o_valid (dn_valid),
         .i_ready (dn_ready),
         .o_data  (dn_data)
      );
   end

   assign o_ready = g_stage[0].up_ready;
   assign o_valid = g_stage[STAGES-1].dn_valid;
   assign o_a     = g_stage[STAGES-1].dn_data;

`ifdef REV_PIPE_COUNT_EN
   logic [COUNT_W-1:0] count_q;

   // Saturating output-transfer counter; clear takes priority over a transfer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else if (i_count_clr) begin
         count_q <= '0;
      end else if (i_en && o_valid && i_ready && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign o_count = count_q;
`endif

endmodule

// File: tb/tb_rev_capture_pipe.sv
// tb_rev_capture_pipe: table vectors, directed handshake sequences and
// randomized traffic against an occupancy/scoreboard reference model.
module tb_rev_capture_pipe;

   localparam int W = 4;
   localparam int L = 2;
   localparam int S = 2;
   localparam int N = W * L;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en = 1'b0;
   logic         valid = 1'b0;
   logic         ready = 1'b0;
   logic [N-1:0] a = '0;
   logic [1:0]   mode = '0;
   logic [W-1:0] a1 = '0;
   logic         o_ready, o_valid;
   logic [N-1:0] o_a;
   logic         o1_ready, o1_valid;
   logic [W-1:0] o1_a;
`ifdef REV_PIPE_COUNT_EN
   logic         count_clr = 1'b0;
   logic [15:0]  o_count, o1_count;
   int           m_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_dut_out = 0;
   int n_dut_acc = 0;

   logic         occ [S];
   logic [N-1:0] exp_q [$];

   always #5 clk = ~clk;

   rev_capture_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(o_ready),
      .i_a(a), .i_mode(mode), .o_valid(o_valid), .i_ready(ready), .o_a(o_a)
`ifdef REV_PIPE_COUNT_EN
      , .i_count_clr(count_clr), .o_count(o_count)
`endif
   );

   rev_capture_pipe #(.WIDTH(W), .LANES(1), .STAGES(S)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(o1_ready),
      .i_a(a1), .i_mode(mode), .o_valid(o1_valid), .i_ready(ready), .o_a(o1_a)
`ifdef REV_PIPE_COUNT_EN
      , .i_count_clr(count_clr), .o_count(o1_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   // Reference permutation for the 2-lane x 4-bit configuration.
   function automatic logic [N-1:0] ref_perm(input logic [N-1:0] x, input logic [1:0] m);
      logic [N-1:0] r;
      logic [W-1:0] lane;
      r = '0;
      case (m)
         2'd0: r = x;
         2'd1: r = {<<{x}};
         2'd2: for (int k = 0; k < L; k++) r[k*W +: W] = x[(L-1-k)*W +: W];
         default: for (int k = 0; k < L; k++) begin
            lane = x[k*W +: W];
            r[k*W +: W] = {<<{lane}};
         end
      endcase
      return r;
   endfunction

   // One clock: drive at negedge, compare before the edge, advance the model after it.
   task automatic cycle(input logic c_en, input logic c_valid, input logic c_ready,
                        input logic [N-1:0] c_a, input logic [1:0] c_mode, output logic c_acc);
      logic m_ready, any_empty, m_xfer;
      int   k;
      en = c_en; valid = c_valid; ready = c_ready; a = c_a; mode = c_mode;
      #1;
      any_empty = 1'b0;
      k = -1;
      for (int s = 0; s < S; s++) if (!occ[s]) begin any_empty = 1'b1; k = s; end
      if (c_ready) k = S - 1;
      m_ready = c_en & (c_ready | any_empty);
      m_xfer  = c_en & c_ready & occ[S-1];
      check("o_ready", 32'(o_ready), 32'(m_ready));
      check("o_valid", 32'(o_valid), 32'(occ[S-1]));
      if (o_valid && c_en && c_ready) n_dut_out++;
      if (c_valid && o_ready) n_dut_acc++;
      if (m_xfer) check("o_a_order", 32'(o_a), 32'(exp_q.pop_front()));
      c_acc = c_valid & m_ready;
      if (c_acc) exp_q.push_back(ref_perm(c_a, c_mode));
`ifdef REV_PIPE_COUNT_EN
      check("o_count", 32'(o_count), 32'(m_count));
`endif
      @(posedge clk);
      if (c_en) begin
         for (int s = S - 1; s >= 1; s--) if (s <= k) occ[s] = occ[s-1];
         if (k >= 0) occ[0] = c_valid;
      end
`ifdef REV_PIPE_COUNT_EN
      if (count_clr) m_count = 0;
      else if (m_xfer && m_count < 65535) m_count++;
`endif
      @(negedge clk);
   endtask

   // Assert reset now (asynchronously), check cleared outputs, release at next negedge.
   task automatic apply_reset();
      rst_n = 1'b0;
      en = 1'b1; valid = 1'b0; ready = 1'b1;
      #1;
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_a", 32'(o_a), 0);
      check("rst_o_ready", 32'(o_ready), 0);
      for (int s = 0; s < S; s++) occ[s] = 1'b0;
      exp_q.delete();
`ifdef REV_PIPE_COUNT_EN
      m_count = 0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] a;
      logic [1:0]   mode;
      logic [N-1:0] exp;
      logic [W-1:0] a1;
      logic [W-1:0] exp1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      logic [N-1:0] nxt;
      int base;

      tbl[0] = '{8'h1E, 2'b00, 8'h1E, 4'h1, 4'h1};
      tbl[1] = '{8'h1E, 2'b01, 8'h78, 4'h1, 4'h8};
      tbl[2] = '{8'h1E, 2'b10, 8'hE1, 4'h3, 4'h3};
      tbl[3] = '{8'h1E, 2'b11, 8'h87, 4'h3, 4'hC};
      tbl[4] = '{8'h12, 2'b01, 8'h48, 4'h6, 4'h6};
      tbl[5] = '{8'h12, 2'b10, 8'h21, 4'h9, 4'h9};
      tbl[6] = '{8'h12, 2'b11, 8'h84, 4'hE, 4'h7};
      tbl[7] = '{8'hF0, 2'b00, 8'hF0, 4'h0, 4'h0};

      #1;
      apply_reset();

      // Single beat latency
      cycle(1, 1, 1, 8'hA5, 2'b00, acc);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);
      #1;
      check("lat_o_valid", 32'(o_valid), 1);
      check("lat_o_a", 32'(o_a), 32'h A5);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);

      // Permutation table, both lane configurations
      for (int i = 0; i < 8; i++) begin
         a1 = tbl[i].a1;
         cycle(1, 1, 1, tbl[i].a, tbl[i].mode, acc);
         cycle(1, 0, 1, 8'h00, tbl[i].mode, acc);
         #1;
         check($sformatf("tbl%0d_o_a", i), 32'(o_a), 32'(tbl[i].exp));
         check($sformatf("tbl%0d_lane1_o_a", i), 32'(o1_a), 32'(tbl[i].exp1));
         check($sformatf("tbl%0d_lane1_o_valid", i), 32'(o1_valid), 1);
         check($sformatf("tbl%0d_lane1_o_ready", i), 32'(o1_ready), 1);
      end
      cycle(1, 0, 1, 8'h00, 2'b00, acc);

      // Backpressure: fill with i_ready low, then drain
      nxt = 8'h01;
      base = n_dut_acc;
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 0, nxt, 2'b00, acc);
         if (acc) nxt++;
      end
      check("bp_accepts", n_dut_acc - base, 2);
      check("bp_hold_o_a", 32'(o_a), 32'h01);
      base = n_dut_out;
      for (int i = 0; i < 5; i++) begin
         cycle(1, nxt <= 8'h05, 1, nxt, 2'b00, acc);
         if (acc) nxt++;
      end
      check("bp_drain_count", n_dut_out - base, 5);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);

      // Enable freeze mid-stream
      nxt = 8'h40;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 1, nxt, 2'b01, acc);
         if (acc) nxt++;
      end
      base = n_dut_out;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 1, N'($urandom), 2'($urandom), acc);
         if (occ[S-1]) check("freeze_o_a", 32'(o_a), 32'(exp_q[0]));
      end
      check("freeze_transfers", n_dut_out - base, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 1, nxt, 2'b01, acc);
         if (acc) nxt++;
      end
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h00, 2'b00, acc);

      // Reset with two beats in flight, then a fresh beat at full latency
      cycle(1, 1, 0, 8'hC3, 2'b10, acc);
      cycle(1, 1, 0, 8'h3C, 2'b11, acc);
      #2;
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h00, 2'b00, acc);
      cycle(1, 1, 1, 8'h5A, 2'b11, acc);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);
      #1;
      check("post_rst_o_a", 32'(o_a), 32'h A5);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);

      // Randomized traffic
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 6, N'($urandom), 2'($urandom), acc);

`ifdef REV_PIPE_COUNT_EN
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, N'(i), 2'b00, acc);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h00, 2'b00, acc);
      check("count_three", 32'(o_count), 3);
      cycle(1, 1, 1, 8'h77, 2'b00, acc);
      cycle(1, 0, 1, 8'h00, 2'b00, acc);
      count_clr = 1'b1;
      cycle(1, 0, 1, 8'h00, 2'b00, acc);
      count_clr = 1'b0;
      check("count_clr_with_xfer", 32'(o_count), 0);
      force dut.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      m_count = 65535;
      for (int i = 0; i < 2; i++) cycle(1, 1, 1, 8'h99, 2'b00, acc);
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'h00, 2'b00, acc);
      check("count_saturate", 32'(o_count), 32'h FFFF);
`endif

      for (int i = 0; i < 4; i++) cycle(1, 0, 1, 8'h00, 2'b00, acc);
      check("drain_o_valid", 32'(o_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rev_capture_pipe.md
Name: rev_capture_pipe

Overview:
Parametrised successor of the single-bit latch-and-flop reversal path. Captures a multi-lane input vector with a flop-based hold gated by i_en; no level-sensitive latches. Applies a selectable bit/lane permutation and carries the result through a configurable valid/ready register pipeline. Sits between a source block and a consumer that applies backpressure.

Parameters:
WIDTH, 4, bits per lane (>=1)
LANES, 1, number of lanes (>=1); total vector N = WIDTH*LANES
STAGES, 2, pipeline register slices (>=1); latency in cycles

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  global enable; low freezes the whole pipeline
i_valid  input  1  input beat valid
o_ready  output  1  block accepts a beat this cycle
i_a  input  N  input vector; lane k = i_a[k*WIDTH +: WIDTH]
i_mode  input  2  permutation, sampled with the beat
o_valid  output  1  output beat valid
i_ready  input  1  consumer accepts the output beat
o_a  output  N  permuted output vector

Behaviour:
- Reset (i_rst_n low, asynchronous): every stage valid=0 and data=0; o_valid=0, o_a=0; o_ready forced 0 while reset is asserted.
- Interface is single clock, i_clk; reset i_rst_n is asynchronous, active-low. Deassertion is taken synchronously by the integrator.
- Permutation is applied combinationally before stage 0; later stages only move data. For result vector r and input a:
  - 2'b00 PASS: r = a.
  - 2'b01 BITREV: r[N-1-j] = a[j]. WIDTH=4, LANES=1 reproduces the legacy o_a[3-k] = a[k] map.
  - 2'b10 LANEREV: lane k of r = lane LANES-1-k of a; bits within each lane unchanged.
  - 2'b11 LANEBITREV: each lane is bit-reversed in place; lane order unchanged.
  - With LANES=1, LANEREV equals PASS and LANEBITREV equals BITREV.
- Stage s accepts when i_en=1 and (stage s is empty, or stage s+1 accepts this cycle). The last stage's downstream accept is i_ready.
- o_ready = i_en & stage-0 accept condition. A beat transfers when i_valid & o_ready.
- o_valid/o_a are the last-stage register outputs directly, with no combinational path from i_a. Output transfers when o_valid & i_ready.
- Latency: a beat accepted in cycle t shows o_valid in cycle t+STAGES if there is no stall.
- Throughput: 1 beat/cycle. When the pipeline is full and i_ready=1, accept and emit happen in the same cycle.
- Backpressure (i_ready=0): the last stage holds o_a stable and keeps o_valid=1. Bubbles upstream collapse. o_ready drops only once every stage is full.
- i_en=0:
  - No accept and no advance; o_ready=0.
  - o_valid/o_a hold their values; an output transfer is suppressed even if i_ready=1.
  - State resumes unchanged when i_en returns to 1.
- Ordering: beats exit in acceptance order. No drops or duplicates outside reset.
- i_mode and i_a are ignored when no transfer occurs.
- Reset mid-operation: all in-flight beats are discarded. The first post-reset beat sees full latency.

Optional Feature:
Macro REV_PIPE_COUNT_EN.
- Defined: adds output o_count [15:0]. It increments on each output transfer, saturates at 16'hFFFF, and resets to 0. It also adds input i_count_clr, a synchronous clear. If clear and a transfer happen in the same cycle, the result is 0.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package rev_pipe_pkg:
  - mode_e enum: MODE_PASS, MODE_BITREV, MODE_LANEREV, MODE_LANEBITREV.
  - Parameterised permutation function rev_permute(a, mode).
  - Localparam for COUNT_W=16.
- Sub-module rev_pipe_slice: one valid+data register with upstream/downstream ready logic, parameterised by N, instantiated STAGES times in a generate loop.
- The top holds the permutation front end and the optional counter.

Test Plan:
All tests use WIDTH=4, LANES=2, STAGES=2 unless stated otherwise.
- Reset/latency: release reset, i_en=1, i_ready=1, one beat i_a=8'hA5, mode 00 → o_valid=0 for 1 cycle, then o_a=8'hA5 with o_valid=1 at cycle t+2 for exactly one cycle.
- Modes on i_a=8'h1E:
  - 00 → 8'h1E; 01 → 8'h78; 10 → 8'hE1; 11 → 8'h87.
  - WIDTH=4, LANES=1, mode 01, i_a=4'b0001 → 4'b1000.
- Backpressure: stream 8'h01..8'h05 with i_ready=0 → o_ready falls after 2 accepts, o_a holds 8'h01. Raise i_ready → 8'h01..8'h05 emerge in order, 1/cycle, none lost.
- Enable freeze: mid-stream drive i_en=0 for 3 cycles with i_valid=1, i_ready=1 → o_ready=0, o_a/o_valid constant, no transfers. Restore i_en → sequence continues intact.
- Reset mid-operation: assert i_rst_n=0 asynchronously with 2 beats in flight → o_valid and o_a go 0 immediately. After release, no stale beat appears.
- With REV_PIPE_COUNT_EN defined: 3 transfers → o_count=3. Assert i_count_clr together with a transfer → o_count=0. Preload 16'hFFFF via transfers (or force) → stays 16'hFFFF.
